// File: rtl/gpio_irq_port.sv
// rtl/gpio_irq_port.sv - 6502-bus GPIO responder: LED register, debounced button, edge IRQ.
// Define GPIO_DEBOUNCE_EN to include the debounce counter; otherwise the level is the synchronized pin.
module gpio_irq_port #(
   parameter logic [15:0] BASE       = 16'h6000,
   parameter int          DEB_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] ab,
   input  logic [7:0]  wdata,
   input  logic        we,
   output logic [7:0]  rdata,
   output logic        sel,
   input  logic        btn,
   output logic [5:0]  led,
   output logic        irq
);

   logic       hit;
   logic       wr;
   logic [1:0] off;
   logic [5:0] led_reg;
   logic [1:0] edge_flags;
   logic [1:0] ien;
   logic       sync1;
   logic       sync2;
   logic       deb;
   logic       deb_next;
   logic       press;
   logic       release_evt;
   logic [1:0] edge_clr;
   logic [1:0] edge_next;
   logic [7:0] rdata_next;
   logic       unused_bits;

   assign hit = (ab[15:2] == BASE[15:2]);
   assign wr  = we & hit;
   assign off = ab[1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   localparam int CW = $clog2(DEB_CYCLES + 1);
   logic [CW-1:0] cnt;
   logic          toggle;

   // Toggle on the edge where the counter would reach DEB_CYCLES.
   assign toggle   = (sync2 != deb) && (cnt == CW'(DEB_CYCLES - 1));
   assign deb_next = deb ^ toggle;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         deb <= 1'b0;
      end else if (sync2 == deb) begin
         cnt <= '0;
      end else if (toggle) begin
         cnt <= '0;
         deb <= ~deb;
      end else if (cnt != '1) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign unused_bits = ^wdata[7:6];
`else
   // Level follows sync2; the transition is seen one stage early at sync1.
   assign deb      = sync2;
   assign deb_next = sync1;
   assign unused_bits = ^{wdata[7:6], (DEB_CYCLES == 0)};
`endif

   assign press       = ~deb & deb_next;
   assign release_evt = deb & ~deb_next;

   assign edge_clr  = (wr && off == 2'd2) ? wdata[1:0] : 2'b00;
   assign edge_next = (edge_flags & ~edge_clr) | {release_evt, press};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         led_reg    <= '0;
         ien        <= '0;
         edge_flags <= '0;
      end else begin
         edge_flags <= edge_next;
         if (wr && off == 2'd0) led_reg <= wdata[5:0];
         if (wr && off == 2'd3) ien <= wdata[1:0];
      end
   end

   always_comb begin
      rdata_next = 8'h00;
      if (hit) begin
         case (off)
            2'd0:    rdata_next = {2'b00, led_reg};
            2'd1:    rdata_next = {6'b0, sync2, deb};
            2'd2:    rdata_next = {6'b0, edge_flags};
            default: rdata_next = {6'b0, ien};
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata <= 8'h00;
         sel   <= 1'b0;
      end else begin
         rdata <= rdata_next;
         sel   <= hit;
      end
   end

   assign led = ~led_reg;
   assign irq = |(edge_flags & ien);

endmodule
